// File: rtl/peasant_mult_ctrl.sv
// Shift-and-add (Russian-peasant) multiplier controller: valid/ready operand
// intake, one conditional add + shift per clock, valid/ready product output.
// Optional early termination on exhausted multiplier: PEASANT_EARLY_TERM_EN.
module peasant_mult_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t             state, state_nxt;
  logic [2*WIDTH-1:0] mcand, mcand_nxt;
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0]   mplier, mplier_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [WIDTH-1:0]   mplier_sh;
  logic               last_iter;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_nxt;
      mcand  <= mcand_nxt;
      mplier <= mplier_nxt;
      acc    <= acc_nxt;
      cnt    <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    mcand_nxt  = mcand;
    mplier_nxt = mplier;
    acc_nxt    = acc;
    cnt_nxt    = cnt;
    mplier_sh  = mplier >> 1;
    last_iter  = (cnt == LAST_ITER);

    case (state)
      IDLE: begin
        if (in_valid) begin
          mcand_nxt  = {{WIDTH{1'b0}}, a};
          mplier_nxt = b;
          acc_nxt    = '0;
          cnt_nxt    = '0;
          state_nxt  = RUN;
`ifdef PEASANT_EARLY_TERM_EN
          // Zero multiplier: product is already known to be zero.
          if (b == '0) state_nxt = DONE;
`endif
        end
      end

      RUN: begin
        if (mplier[0]) acc_nxt = acc + mcand;
        mcand_nxt  = mcand << 1;
        mplier_nxt = mplier_sh;
        cnt_nxt    = cnt + CNT_W'(1);
`ifdef PEASANT_EARLY_TERM_EN
        if (last_iter || (mplier_sh == '0)) state_nxt = DONE;
`else
        if (last_iter) state_nxt = DONE;
`endif
      end

      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign product   = acc;

endmodule

// File: tb/tb_peasant_mult_ctrl.sv
// Directed self-checking bench for peasant_mult_ctrl (WIDTH=16); expected
// latencies follow PEASANT_EARLY_TERM_EN when the build defines it.
module tb_peasant_mult_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  peasant_mult_ctrl #(.WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Full transaction: accept, wait for out_valid (bounded), optional
  // back-pressure with a competing in_valid, then drain.
  task automatic run_op(input string tag, input logic [15:0] oa, input logic [15:0] ob,
                        input logic [31:0] exp, input int exp_lat, input int hold);
    int   lat;
    logic rdy_bad;
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    a = oa;
    b = ob;
    chk($sformatf("%s.in_ready_idle", tag), 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    lat = 0;
    rdy_bad = 1'b0;
    while (!out_valid && lat < 64) begin
      if (in_ready || !busy) rdy_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("%s.latency", tag), 64'(lat), 64'(exp_lat));
    chk($sformatf("%s.product", tag), 64'(product), 64'(exp));
    chk($sformatf("%s.in_ready_low_busy", tag), 64'(rdy_bad), 64'(0));
    if (hold > 0) begin
      in_valid = 1'b1;
      a = 16'h0001;
      b = 16'h0001;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        chk($sformatf("%s.hold%0d.out_valid", tag, i), 64'(out_valid), 64'(1));
        chk($sformatf("%s.hold%0d.product", tag, i), 64'(product), 64'(exp));
        chk($sformatf("%s.hold%0d.in_ready", tag, i), 64'(in_ready), 64'(0));
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk($sformatf("%s.drain.out_valid", tag), 64'(out_valid), 64'(0));
    chk($sformatf("%s.drain.in_ready", tag), 64'(in_ready), 64'(1));
    chk($sformatf("%s.drain.busy", tag), 64'(busy), 64'(0));
  endtask

`ifdef PEASANT_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.in_ready", 64'(in_ready), 64'(1));
    chk("reset.out_valid", 64'(out_valid), 64'(0));
    chk("reset.product", 64'(product), 64'(0));
    chk("reset.busy", 64'(busy), 64'(0));
    reset = 1'b0;

    // Idle with no handshake stays idle.
    @(posedge clk); #1;
    chk("idle.busy", 64'(busy), 64'(0));

    run_op("m3x5",       16'h0003, 16'h0005, 32'h0000_000F, ET ? 3  : 16, 0);
    run_op("mffffxffff", 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 16,            0);
    run_op("m1234x1",    16'h1234, 16'h0001, 32'h0000_1234, ET ? 1  : 16, 0);
    run_op("mabcdx0",    16'hABCD, 16'h0000, 32'h0000_0000, ET ? 0  : 16, 0);
    run_op("m0x1234",    16'h0000, 16'h1234, 32'h0000_0000, ET ? 13 : 16, 0);
    run_op("m8000x8000", 16'h8000, 16'h8000, 32'h4000_0000, 16,            0);
    run_op("m7x9",       16'h0007, 16'h0009, 32'h0000_003F, ET ? 4  : 16, 5);

    // Reset in the middle of RUN: edge of iteration 6 is the reset edge.
    in_valid = 1'b1;
    a = 16'h00FF;
    b = 16'h0F0F;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("midreset.busy_before", 64'(busy), 64'(1));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midreset.in_ready", 64'(in_ready), 64'(1));
    chk("midreset.out_valid", 64'(out_valid), 64'(0));
    chk("midreset.product", 64'(product), 64'(0));
    chk("midreset.busy", 64'(busy), 64'(0));

    run_op("m2x3", 16'h0002, 16'h0003, 32'h0000_0006, ET ? 2 : 16, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
